// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants and receiver state encoding
package midi_pkg;

    localparam int MIDI_BAUD     = 31250;
    localparam int MIDI_CLK_FREQ = 16000000;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = RX_IDLE,
        ST_START = RX_START,
        ST_DATA  = RX_DATA,
        ST_STOP  = RX_STOP,
        ST_BREAK = RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/midi_baud_tick.sv
// rtl/midi_baud_tick.sv - clearable clock divider producing a one-clock oversample tick
module midi_baud_tick #(
    parameter int DIV       = 32,
    parameter int DIV_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV - 1);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Count 0..DIV-1; clear holds the phase at zero so the first tick lands DIV clocks after release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI IN 8N1 receiver feeding the byte FIFO with framing/overrun pulses
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ   = MIDI_CLK_FREQ,
    parameter int BAUD       = MIDI_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE),
    parameter int DIV_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       full_n,
    output logic       wr,
    output logic [7:0] data_o,
    output logic       framing_err,
    output logic       overrun
);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    logic      r_rx_meta;
    logic      r_rx_s;
    rx_state_t r_state;
    logic [3:0] r_sample_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_wr;
    logic [7:0] r_data;
    logic       r_ferr;
    logic       r_ovr;

    rx_state_t  w_state_nxt;
    logic [3:0] w_sample_nxt;
    logic [2:0] w_bit_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_wr_nxt;
    logic [7:0] w_data_nxt;
    logic       w_ferr_nxt;
    logic       w_ovr_nxt;
    logic       w_tick;
    logic       w_tick_clear;
    logic       w_mid_bit;
    logic       w_end_bit;

    // Two-flop synchroniser; idles high so reset does not look like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick_clear = (r_state == ST_IDLE);

    midi_baud_tick #(
        .DIV       (DIV),
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_tick_clear),
        .o_tick  (w_tick)
    );

    assign w_mid_bit = w_tick && (r_sample_cnt == MID_TICK);
    assign w_end_bit = w_tick && (r_sample_cnt == LAST_TICK);

    // Next-state, sampling and output decisions for the frame FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_wr_nxt     = 1'b0;
        w_data_nxt   = r_data;
        w_ferr_nxt   = 1'b0;
        w_ovr_nxt    = 1'b0;

        if (w_tick) begin
            w_sample_nxt = r_sample_cnt + 4'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_mid_bit) begin
                    if (!r_rx_s) begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_end_bit) begin
                    w_shift_nxt[r_bit_cnt] = r_rx_s;
                    w_bit_nxt              = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_end_bit) begin
                    if (r_rx_s) begin
                        if (full_n) begin
                            w_wr_nxt   = 1'b1;
                            w_data_nxt = r_shift;
                        end else begin
                            w_ovr_nxt = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every state starts its tick count from zero so mid-bit points line up
        if (w_state_nxt != r_state) begin
            w_sample_nxt = 4'd0;
        end
    end

    // Register FSM state, datapath and the single-cycle output strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_wr         <= 1'b0;
            r_data       <= 8'h00;
            r_ferr       <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sample_cnt <= w_sample_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_wr         <= w_wr_nxt;
            r_data       <= w_data_nxt;
            r_ferr       <= w_ferr_nxt;
            r_ovr        <= w_ovr_nxt;
        end
    end

    assign wr          = r_wr;
    assign data_o      = r_data;
    assign framing_err = r_ferr;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - randomized and directed self-checking bench for midi_uart_rx
module tb_midi_uart_rx;

    // 16 MHz / 31250 baud = 512 clocks per serial bit
    localparam int BIT   = 16000000 / 31250;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       full_n;
    logic       wr;
    logic [7:0] data_o;
    logic       framing_err;
    logic       overrun;

    midi_uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .full_n      (full_n),
        .wr          (wr),
        .data_o      (data_o),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         excl_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr === 1'b1) begin
                wr_data_q.push_back(data_o);
                wr_cyc_q.push_back(cyc);
            end
            if (framing_err === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if ((int'(wr === 1'b1) + int'(framing_err === 1'b1) + int'(overrun === 1'b1)) > 1) excl_cnt++;
        end
    end

    // Reference model: outcome of a frame depends only on stop level and FIFO space
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    logic [7:0] exp_data = 8'h00;

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic fn);
        if (!stop) begin
            exp_ferr++;
        end else if (!fn) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_step(input string tag);
        logic [7:0] o;
        logic [7:0] e;
        chk({tag, "_wr_count"}, wr_data_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
            o = wr_data_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_wr_data"}, {24'h0, o}, {24'h0, e});
        end
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        chk({tag, "_framing_err"}, ferr_cnt, exp_ferr);
        chk({tag, "_overrun"}, ovr_cnt, exp_ovr);
        chk({tag, "_data_o"}, {24'h0, data_o}, {24'h0, exp_data});
        chk({tag, "_exclusive"}, excl_cnt, 0);
    endtask

    // Drivers assume they are entered on a falling clock edge
    task automatic drive_level(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    int t_start;

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_start = cyc;
        drive_level(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_level(b[i], BIT);
        drive_level(stop, BIT);
    endtask

    logic [7:0] rb;
    logic       rstop;
    logic       rfn;
    int         lat;

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        full_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_wr", {31'h0, wr}, 0);
        chk("reset_data_o", {24'h0, data_o}, 0);
        chk("reset_framing_err", {31'h0, framing_err}, 0);
        chk("reset_overrun", {31'h0, overrun}, 0);
        @(negedge clk);
        reset = 1'b0;
        drive_level(1'b1, 20);

        // Single byte and its latency from the falling start edge
        send_frame(8'h90, 1'b1);
        model_frame(8'h90, 1'b1, 1'b1);
        lat = (wr_cyc_q.size() > 0) ? (wr_cyc_q[0] - t_start) : -1;
        chk("latency_in_window", {31'h0, (lat >= 4866 && lat <= 4868)}, 1);
        check_step("single_90");
        drive_level(1'b1, BIT);

        // Three frames back to back with one stop bit each
        send_frame(8'h90, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7F, 1'b1);
        model_frame(8'h90, 1'b1, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b1);
        model_frame(8'h7F, 1'b1, 1'b1);
        if (wr_cyc_q.size() == 3) begin
            chk("b2b_gap1", {31'h0, ((wr_cyc_q[1] - wr_cyc_q[0]) >= FRAME - 1 && (wr_cyc_q[1] - wr_cyc_q[0]) <= FRAME + 1)}, 1);
            chk("b2b_gap2", {31'h0, ((wr_cyc_q[2] - wr_cyc_q[1]) >= FRAME - 1 && (wr_cyc_q[2] - wr_cyc_q[1]) <= FRAME + 1)}, 1);
        end
        check_step("back_to_back");
        drive_level(1'b1, BIT);

        // Three-tick glitch must be rejected silently
        drive_level(1'b0, 96);
        drive_level(1'b1, BIT);
        check_step("glitch");
        send_frame(8'h45, 1'b1);
        model_frame(8'h45, 1'b1, 1'b1);
        check_step("after_glitch");
        drive_level(1'b1, BIT / 2);

        // Framing error followed by a held break, then a clean byte
        send_frame(8'hF8, 1'b0);
        drive_level(1'b0, BIT);
        model_frame(8'hF8, 1'b0, 1'b1);
        drive_level(1'b1, BIT);
        check_step("framing");
        send_frame(8'hFE, 1'b1);
        model_frame(8'hFE, 1'b1, 1'b1);
        check_step("after_break");
        drive_level(1'b1, BIT / 2);

        // FIFO full drops the byte; retry with space lands it
        full_n = 1'b0;
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_step("overrun");
        full_n = 1'b1;
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b1);
        check_step("after_overrun");
        drive_level(1'b1, BIT / 2);

        // Reset in the middle of data bit 4 of 0x55
        rb = 8'h55;
        drive_level(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_level(rb[i], BIT);
        rx = rb[4];
        repeat (BIT / 2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_data = 8'h00;
        chk("midreset_wr", {31'h0, wr}, 0);
        chk("midreset_data_o", {24'h0, data_o}, 0);
        chk("midreset_framing_err", {31'h0, framing_err}, 0);
        chk("midreset_overrun", {31'h0, overrun}, 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        drive_level(1'b1, 2 * BIT);
        check_step("reset_abort");
        send_frame(8'hAA, 1'b1);
        model_frame(8'hAA, 1'b1, 1'b1);
        check_step("after_reset");
        drive_level(1'b1, BIT / 2);

        // Randomized bytes, stop levels and FIFO space
        for (int k = 0; k < 3; k++) begin
            rb     = 8'($urandom_range(0, 255));
            rstop  = ($urandom_range(0, 3) != 0);
            rfn    = 1'($urandom_range(0, 1));
            full_n = rfn;
            send_frame(rb, rstop);
            model_frame(rb, rstop, rfn);
            full_n = 1'b1;
            drive_level(1'b1, BIT / 2);
            check_step($sformatf("random%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
